// File: rtl/data_transfer_ctrl.sv
// ============================================================================
// Module   : data_transfer_ctrl
// Brief    : SD DATA-line transfer sequencer between host side and DATA_PHYSICAL.
//            Optional block retry on data timeout: define DATA_CTRL_RETRY_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_transfer_ctrl #(
    parameter int BLK_W    = 4,
    parameter int TO_W     = 16,
    parameter int ACK_WAIT = 255
) (
    input  logic             SD_CLK,
    input  logic             RESET,
    input  logic             start_Host_DATA,
    input  logic             abort_Host_DATA,
    input  logic             writeRead_Host_DATA,
    input  logic [BLK_W-1:0] blocks_Host_DATA,
    input  logic [TO_W-1:0]  timeout_Host_DATA,
    input  logic             fifo_ready_FIFO_DATA,
    output logic             busy_DATA_Host,
    output logic             done_DATA_Host,
    output logic [1:0]       error_code_DATA_Host,
    output logic [BLK_W-1:0] blocks_done_DATA_Host,
    output logic             retried_DATA_Host,
    output logic             strobe_IN_DATA_Phy,
    output logic             ack_IN_DATA_Phy,
    output logic [TO_W-1:0]  timeout_Reg_DATA_Phy,
    output logic [BLK_W-1:0] blocks_DATA_Phy,
    output logic             writeRead_DATA_Phy,
    output logic             multiple_DATA_Phy,
    output logic             idle_in_DATA_Phy,
    input  logic             serial_Ready_Phy_DATA,
    input  logic             complete_Phy_DATA,
    input  logic             ack_OUT_Phy_DATA,
    input  logic             data_timeout_Phy_DATA
);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_SETUP  = 3'd1;
    localparam logic [2:0] c_WAIT   = 3'd2;
    localparam logic [2:0] c_STROBE = 3'd3;
    localparam logic [2:0] c_ACK    = 3'd4;
    localparam logic [2:0] c_FINISH = 3'd5;
    localparam logic [2:0] c_FAIL   = 3'd6;
    localparam logic [2:0] c_RETRY  = 3'd7;

    localparam logic [7:0] c_ACK_LAST = 8'(ACK_WAIT - 1);

    logic [2:0]       r_state;
    logic [7:0]       r_ack_cnt;
    logic [2:0]       w_next;
    logic [1:0]       w_fail_code;
    logic             w_blk_done;
    logic             w_active;
    logic             w_start_ok;
    logic             w_start_zero;
    logic [BLK_W-1:0] w_done_inc;

    // FINISH and FAIL are terminal: an abort there has nothing left to cancel.
    assign w_active     = (r_state != c_IDLE) && (r_state != c_FINISH) && (r_state != c_FAIL);
    assign w_start_ok   = (r_state == c_IDLE) && start_Host_DATA && (blocks_Host_DATA != '0);
    assign w_start_zero = (r_state == c_IDLE) && start_Host_DATA && (blocks_Host_DATA == '0);
    assign w_done_inc   = blocks_done_DATA_Host + 1'b1;

`ifdef DATA_CTRL_RETRY_EN
    logic r_retry_used;
    logic w_retry;
`endif

    always_comb begin
        w_next      = r_state;
        w_fail_code = 2'd0;
        w_blk_done  = 1'b0;
`ifdef DATA_CTRL_RETRY_EN
        w_retry     = 1'b0;
`endif
        if (abort_Host_DATA && w_active) begin
            w_next      = c_FAIL;
            w_fail_code = 2'd3;
        end else begin
            case (r_state)
                c_IDLE:   if (w_start_ok) w_next = c_SETUP;
                c_SETUP:  w_next = c_WAIT;
                c_WAIT:   if (serial_Ready_Phy_DATA && fifo_ready_FIFO_DATA) w_next = c_STROBE;
                c_STROBE: begin
                    if (complete_Phy_DATA) begin
                        w_next = c_ACK;
                    end else if (data_timeout_Phy_DATA) begin
`ifdef DATA_CTRL_RETRY_EN
                        if (!r_retry_used) begin
                            w_next  = c_RETRY;
                            w_retry = 1'b1;
                        end else begin
                            w_next      = c_FAIL;
                            w_fail_code = 2'd1;
                        end
`else
                        w_next      = c_FAIL;
                        w_fail_code = 2'd1;
`endif
                    end
                end
                c_ACK: begin
                    if (ack_OUT_Phy_DATA) begin
                        w_blk_done = 1'b1;
                        w_next     = (w_done_inc == blocks_DATA_Phy) ? c_FINISH : c_WAIT;
                    end else if (r_ack_cnt == c_ACK_LAST) begin
                        w_next      = c_FAIL;
                        w_fail_code = 2'd2;
                    end
                end
                c_RETRY:  w_next = c_WAIT;
                default:  w_next = c_IDLE;
            endcase
        end
    end

    always_ff @(posedge SD_CLK) begin
        if (RESET) begin
            r_state               <= c_IDLE;
            r_ack_cnt             <= 8'd0;
            busy_DATA_Host        <= 1'b0;
            done_DATA_Host        <= 1'b0;
            error_code_DATA_Host  <= 2'd0;
            blocks_done_DATA_Host <= '0;
            strobe_IN_DATA_Phy    <= 1'b0;
            ack_IN_DATA_Phy       <= 1'b0;
            timeout_Reg_DATA_Phy  <= '0;
            blocks_DATA_Phy       <= '0;
            writeRead_DATA_Phy    <= 1'b0;
            multiple_DATA_Phy     <= 1'b0;
            idle_in_DATA_Phy      <= 1'b1;
        end else begin
            r_state            <= w_next;
            done_DATA_Host     <= (w_next == c_FINISH) || (w_next == c_FAIL) || w_start_zero;
            strobe_IN_DATA_Phy <= (w_next == c_STROBE);
            ack_IN_DATA_Phy    <= (w_next == c_ACK);
            busy_DATA_Host     <= (w_next == c_SETUP) || (w_next == c_WAIT) ||
                                  (w_next == c_STROBE) || (w_next == c_ACK) || (w_next == c_RETRY);
            idle_in_DATA_Phy   <= !((w_next == c_SETUP) || (w_next == c_WAIT) ||
                                    (w_next == c_STROBE) || (w_next == c_ACK));

            if (w_start_ok || w_start_zero) error_code_DATA_Host <= 2'd0;
            else if (w_fail_code != 2'd0)   error_code_DATA_Host <= w_fail_code;

            if (w_start_ok) begin
                writeRead_DATA_Phy    <= writeRead_Host_DATA;
                blocks_DATA_Phy       <= blocks_Host_DATA;
                timeout_Reg_DATA_Phy  <= timeout_Host_DATA;
                multiple_DATA_Phy     <= (blocks_Host_DATA > 1);
                blocks_done_DATA_Host <= '0;
            end else if (w_blk_done && (blocks_done_DATA_Host != blocks_DATA_Phy)) begin
                blocks_done_DATA_Host <= w_done_inc;
            end

            if ((w_next == c_ACK) && (r_state != c_ACK)) r_ack_cnt <= 8'd0;
            else if (r_state == c_ACK)                  r_ack_cnt <= r_ack_cnt + 8'd1;
        end
    end

`ifdef DATA_CTRL_RETRY_EN
    // One retry credit per block; refilled when a block completes.
    always_ff @(posedge SD_CLK) begin
        if (RESET) begin
            r_retry_used      <= 1'b0;
            retried_DATA_Host <= 1'b0;
        end else if (w_start_ok) begin
            r_retry_used      <= 1'b0;
            retried_DATA_Host <= 1'b0;
        end else if (w_retry) begin
            r_retry_used      <= 1'b1;
            retried_DATA_Host <= 1'b1;
        end else if (w_blk_done) begin
            r_retry_used      <= 1'b0;
        end
    end
`else
    assign retried_DATA_Host = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_data_transfer_ctrl.sv
// ============================================================================
// Module   : tb_data_transfer_ctrl
// Brief    : Directed self-checking bench for data_transfer_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_data_transfer_ctrl;

    logic        SD_CLK = 1'b0;
    logic        RESET;
    logic        start_Host_DATA, abort_Host_DATA, writeRead_Host_DATA;
    logic [3:0]  blocks_Host_DATA;
    logic [15:0] timeout_Host_DATA;
    logic        fifo_ready_FIFO_DATA;
    logic        busy_DATA_Host, done_DATA_Host, retried_DATA_Host;
    logic [1:0]  error_code_DATA_Host;
    logic [3:0]  blocks_done_DATA_Host, blocks_DATA_Phy;
    logic        strobe_IN_DATA_Phy, ack_IN_DATA_Phy;
    logic [15:0] timeout_Reg_DATA_Phy;
    logic        writeRead_DATA_Phy, multiple_DATA_Phy, idle_in_DATA_Phy;
    logic        serial_Ready_Phy_DATA, complete_Phy_DATA, ack_OUT_Phy_DATA, data_timeout_Phy_DATA;

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;
    int rises = 0;
    logic prev_strobe = 1'b0;

    data_transfer_ctrl #(.BLK_W(4), .TO_W(16), .ACK_WAIT(255)) dut (
        .SD_CLK(SD_CLK), .RESET(RESET),
        .start_Host_DATA(start_Host_DATA), .abort_Host_DATA(abort_Host_DATA),
        .writeRead_Host_DATA(writeRead_Host_DATA), .blocks_Host_DATA(blocks_Host_DATA),
        .timeout_Host_DATA(timeout_Host_DATA), .fifo_ready_FIFO_DATA(fifo_ready_FIFO_DATA),
        .busy_DATA_Host(busy_DATA_Host), .done_DATA_Host(done_DATA_Host),
        .error_code_DATA_Host(error_code_DATA_Host), .blocks_done_DATA_Host(blocks_done_DATA_Host),
        .retried_DATA_Host(retried_DATA_Host), .strobe_IN_DATA_Phy(strobe_IN_DATA_Phy),
        .ack_IN_DATA_Phy(ack_IN_DATA_Phy), .timeout_Reg_DATA_Phy(timeout_Reg_DATA_Phy),
        .blocks_DATA_Phy(blocks_DATA_Phy), .writeRead_DATA_Phy(writeRead_DATA_Phy),
        .multiple_DATA_Phy(multiple_DATA_Phy), .idle_in_DATA_Phy(idle_in_DATA_Phy),
        .serial_Ready_Phy_DATA(serial_Ready_Phy_DATA), .complete_Phy_DATA(complete_Phy_DATA),
        .ack_OUT_Phy_DATA(ack_OUT_Phy_DATA), .data_timeout_Phy_DATA(data_timeout_Phy_DATA)
    );

    always #5 SD_CLK = ~SD_CLK;

    always @(negedge SD_CLK) begin
        if (done_DATA_Host) done_cnt++;
        if (strobe_IN_DATA_Phy && !prev_strobe) rises++;
        prev_strobe = strobe_IN_DATA_Phy;
    end

    task automatic tick();
        @(posedge SD_CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_strobe(input string tag);
        int n = 0;
        while (!strobe_IN_DATA_Phy && n < 60) begin
            tick();
            n++;
        end
        chk(tag, {31'd0, strobe_IN_DATA_Phy}, 32'd1);
    endtask

    // One full block: strobe, complete after 3 strobe cycles, ack_OUT after 1 ack cycle.
    task automatic block_hs(input string tag, input logic hold_fifo);
        wait_strobe({tag, "_strobe"});
        repeat (2) tick();
        complete_Phy_DATA = 1'b1;
        tick();
        complete_Phy_DATA = 1'b0;
        chk({tag, "_ack"}, {31'd0, ack_IN_DATA_Phy}, 32'd1);
        ack_OUT_Phy_DATA = 1'b1;
        if (hold_fifo) fifo_ready_FIFO_DATA = 1'b0;
        tick();
        ack_OUT_Phy_DATA = 1'b0;
    endtask

    initial begin
        int n, d0, r0;
        RESET = 1'b1;
        start_Host_DATA = 1'b0; abort_Host_DATA = 1'b0; writeRead_Host_DATA = 1'b0;
        blocks_Host_DATA = 4'd0; timeout_Host_DATA = 16'd0;
        fifo_ready_FIFO_DATA = 1'b1; serial_Ready_Phy_DATA = 1'b1;
        complete_Phy_DATA = 1'b0; ack_OUT_Phy_DATA = 1'b0; data_timeout_Phy_DATA = 1'b0;
        tick(); tick();
        chk("rst_idle_in", {31'd0, idle_in_DATA_Phy}, 32'd1);
        chk("rst_busy", {31'd0, busy_DATA_Host}, 32'd0);
        chk("rst_done", {31'd0, done_DATA_Host}, 32'd0);
        chk("rst_strobe", {31'd0, strobe_IN_DATA_Phy}, 32'd0);
        chk("rst_blocks_done", {28'd0, blocks_done_DATA_Host}, 32'd0);
        chk("rst_err", {30'd0, error_code_DATA_Host}, 32'd0);
        RESET = 1'b0;
        tick();

        // Single-block write
        writeRead_Host_DATA = 1'b1; blocks_Host_DATA = 4'd1; timeout_Host_DATA = 16'h0100;
        start_Host_DATA = 1'b1;
        tick();
        start_Host_DATA = 1'b0;
        chk("s1_busy", {31'd0, busy_DATA_Host}, 32'd1);
        chk("s1_idle_in", {31'd0, idle_in_DATA_Phy}, 32'd0);
        chk("s1_multiple", {31'd0, multiple_DATA_Phy}, 32'd0);
        chk("s1_dir", {31'd0, writeRead_DATA_Phy}, 32'd1);
        chk("s1_timeout", {16'd0, timeout_Reg_DATA_Phy}, 32'h100);
        chk("s1_blocks", {28'd0, blocks_DATA_Phy}, 32'd1);
        chk("s1_strobe_setup", {31'd0, strobe_IN_DATA_Phy}, 32'd0);
        tick();
        chk("s1_strobe_wait", {31'd0, strobe_IN_DATA_Phy}, 32'd0);
        tick();
        chk("s1_strobe", {31'd0, strobe_IN_DATA_Phy}, 32'd1);
        repeat (9) tick();
        chk("s1_strobe_hold", {31'd0, strobe_IN_DATA_Phy}, 32'd1);
        complete_Phy_DATA = 1'b1;
        tick();
        complete_Phy_DATA = 1'b0;
        chk("s1_ack", {31'd0, ack_IN_DATA_Phy}, 32'd1);
        chk("s1_strobe_off", {31'd0, strobe_IN_DATA_Phy}, 32'd0);
        tick();
        chk("s1_ack_hold", {31'd0, ack_IN_DATA_Phy}, 32'd1);
        ack_OUT_Phy_DATA = 1'b1;
        tick();
        ack_OUT_Phy_DATA = 1'b0;
        chk("s1_done", {31'd0, done_DATA_Host}, 32'd1);
        chk("s1_blocks_done", {28'd0, blocks_done_DATA_Host}, 32'd1);
        chk("s1_err", {30'd0, error_code_DATA_Host}, 32'd0);
        chk("s1_ack_drop", {31'd0, ack_IN_DATA_Phy}, 32'd0);
        tick();
        chk("s1_done_end", {31'd0, done_DATA_Host}, 32'd0);
        chk("s1_busy_end", {31'd0, busy_DATA_Host}, 32'd0);
        chk("s1_idle_end", {31'd0, idle_in_DATA_Phy}, 32'd1);

        // Four-block read with FIFO stall before block 3
        writeRead_Host_DATA = 1'b0; blocks_Host_DATA = 4'd4;
        start_Host_DATA = 1'b1;
        d0 = done_cnt; r0 = rises;
        tick();
        start_Host_DATA = 1'b0;
        chk("s2_multiple", {31'd0, multiple_DATA_Phy}, 32'd1);
        chk("s2_dir", {31'd0, writeRead_DATA_Phy}, 32'd0);
        block_hs("s2_b1", 1'b0);
        chk("s2_bd1", {28'd0, blocks_done_DATA_Host}, 32'd1);
        chk("s2_nodone1", {31'd0, done_DATA_Host}, 32'd0);
        block_hs("s2_b2", 1'b1);
        chk("s2_bd2", {28'd0, blocks_done_DATA_Host}, 32'd2);
        n = 0;
        repeat (20) begin
            tick();
            if (strobe_IN_DATA_Phy) n++;
        end
        chk("s2_fifo_stall", n, 32'd0);
        fifo_ready_FIFO_DATA = 1'b1;
        block_hs("s2_b3", 1'b0);
        chk("s2_bd3", {28'd0, blocks_done_DATA_Host}, 32'd3);
        block_hs("s2_b4", 1'b0);
        chk("s2_done", {31'd0, done_DATA_Host}, 32'd1);
        chk("s2_bd4", {28'd0, blocks_done_DATA_Host}, 32'd4);
        tick();
        chk("s2_done_count", done_cnt - d0, 32'd1);
        chk("s2_strobe_count", rises - r0, 32'd4);

        // Data timeout on block 2 of 2
        writeRead_Host_DATA = 1'b1; blocks_Host_DATA = 4'd2;
        start_Host_DATA = 1'b1;
        tick();
        start_Host_DATA = 1'b0;
        block_hs("s3_b1", 1'b0);
        wait_strobe("s3_b2_strobe");
        repeat (2) tick();
        data_timeout_Phy_DATA = 1'b1;
        tick();
        data_timeout_Phy_DATA = 1'b0;
`ifdef DATA_CTRL_RETRY_EN
        chk("s3_retry_strobe", {31'd0, strobe_IN_DATA_Phy}, 32'd0);
        chk("s3_retry_idle", {31'd0, idle_in_DATA_Phy}, 32'd1);
        chk("s3_retry_flag", {31'd0, retried_DATA_Host}, 32'd1);
        chk("s3_retry_nodone", {31'd0, done_DATA_Host}, 32'd0);
        block_hs("s3_b2r", 1'b0);
        chk("s3_done", {31'd0, done_DATA_Host}, 32'd1);
        chk("s3_err", {30'd0, error_code_DATA_Host}, 32'd0);
        chk("s3_bd", {28'd0, blocks_done_DATA_Host}, 32'd2);
        chk("s3_retried", {31'd0, retried_DATA_Host}, 32'd1);
`else
        chk("s3_done", {31'd0, done_DATA_Host}, 32'd1);
        chk("s3_err", {30'd0, error_code_DATA_Host}, 32'd1);
        chk("s3_bd", {28'd0, blocks_done_DATA_Host}, 32'd1);
        chk("s3_idle", {31'd0, idle_in_DATA_Phy}, 32'd1);
        chk("s3_strobe", {31'd0, strobe_IN_DATA_Phy}, 32'd0);
        chk("s3_retried", {31'd0, retried_DATA_Host}, 32'd0);
`endif
        tick();

        // Ack timeout
        blocks_Host_DATA = 4'd1;
        start_Host_DATA = 1'b1;
        tick();
        start_Host_DATA = 1'b0;
        wait_strobe("s4_strobe");
        tick();
        complete_Phy_DATA = 1'b1;
        tick();
        complete_Phy_DATA = 1'b0;
        n = 0;
        while (ack_IN_DATA_Phy && n < 400) begin
            n++;
            tick();
        end
        chk("s4_ack_cycles", n, 32'd255);
        chk("s4_done", {31'd0, done_DATA_Host}, 32'd1);
        chk("s4_err", {30'd0, error_code_DATA_Host}, 32'd2);
        chk("s4_ack_off", {31'd0, ack_IN_DATA_Phy}, 32'd0);
        tick();

        // Abort in STROBE, start while busy, abort in IDLE, zero-block start
        blocks_Host_DATA = 4'd3;
        start_Host_DATA = 1'b1;
        tick();
        start_Host_DATA = 1'b0;
        wait_strobe("s5_strobe");
        blocks_Host_DATA = 4'd7;
        start_Host_DATA = 1'b1;
        tick();
        start_Host_DATA = 1'b0;
        chk("s5_busy_start", {28'd0, blocks_DATA_Phy}, 32'd3);
        tick();
        abort_Host_DATA = 1'b1;
        tick();
        abort_Host_DATA = 1'b0;
        chk("s5_strobe_off", {31'd0, strobe_IN_DATA_Phy}, 32'd0);
        chk("s5_err", {30'd0, error_code_DATA_Host}, 32'd3);
        chk("s5_done", {31'd0, done_DATA_Host}, 32'd1);
        tick();
        abort_Host_DATA = 1'b1;
        tick();
        abort_Host_DATA = 1'b0;
        chk("s5_idle_abort_done", {31'd0, done_DATA_Host}, 32'd0);
        chk("s5_err_hold", {30'd0, error_code_DATA_Host}, 32'd3);
        blocks_Host_DATA = 4'd0;
        start_Host_DATA = 1'b1;
        r0 = rises;
        tick();
        start_Host_DATA = 1'b0;
        chk("s5_zero_done", {31'd0, done_DATA_Host}, 32'd1);
        chk("s5_zero_err", {30'd0, error_code_DATA_Host}, 32'd0);
        chk("s5_zero_busy", {31'd0, busy_DATA_Host}, 32'd0);
        tick();
        chk("s5_zero_done_end", {31'd0, done_DATA_Host}, 32'd0);
        chk("s5_zero_nostrobe", rises - r0, 32'd0);
        blocks_Host_DATA = 4'd1;
        start_Host_DATA = 1'b1; abort_Host_DATA = 1'b1;
        tick();
        start_Host_DATA = 1'b0; abort_Host_DATA = 1'b0;
        chk("s5_start_abort", {31'd0, busy_DATA_Host}, 32'd1);
        block_hs("s5_b1", 1'b0);
        chk("s5_sa_done", {31'd0, done_DATA_Host}, 32'd1);
        tick();

        // Reset during ACK
        blocks_Host_DATA = 4'd2;
        start_Host_DATA = 1'b1;
        tick();
        start_Host_DATA = 1'b0;
        block_hs("s6_b1", 1'b0);
        wait_strobe("s6_strobe");
        tick();
        complete_Phy_DATA = 1'b1;
        tick();
        complete_Phy_DATA = 1'b0;
        chk("s6_in_ack", {31'd0, ack_IN_DATA_Phy}, 32'd1);
        d0 = done_cnt;
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        chk("s6_ack", {31'd0, ack_IN_DATA_Phy}, 32'd0);
        chk("s6_busy", {31'd0, busy_DATA_Host}, 32'd0);
        chk("s6_idle", {31'd0, idle_in_DATA_Phy}, 32'd1);
        chk("s6_bd", {28'd0, blocks_done_DATA_Host}, 32'd0);
        chk("s6_done", {31'd0, done_DATA_Host}, 32'd0);
        tick();
        chk("s6_no_done_pulse", done_cnt - d0, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
